// File: rtl/cpu_core_mc.sv
// Multi-cycle 16-bit-instruction CPU core: FETCH/DECODE/EXEC/WB FSM with an
// 8-entry register file, registered flags and a req/ack instruction fetch port.
module cpu_core_mc #(
   parameter int             DW       = 16,
   parameter int             PCW      = 8,
   parameter logic [PCW-1:0] RESET_PC = '0
) (
   input  logic           clk,
   input  logic           rst_n,
   output logic           imem_req,
   output logic [PCW-1:0] imem_addr,
   input  logic           imem_ack,
   input  logic [15:0]    imem_rdata,
   input  logic [2:0]     dbg_raddr,
   output logic [DW-1:0]  dbg_rdata,
   output logic [PCW-1:0] pc,
   output logic           carry,
   output logic           zero,
   output logic           retire,
   output logic           halted,
   output logic           illegal
);

   localparam int SHW = $clog2(DW);

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_SLL  = 4'd5;
   localparam logic [3:0] OP_SRL  = 4'd6;
   localparam logic [3:0] OP_ADDI = 4'd7;
   localparam logic [3:0] OP_LDI  = 4'd8;
   localparam logic [3:0] OP_BEQZ = 4'd9;
   localparam logic [3:0] OP_JMP  = 4'd10;
   localparam logic [3:0] OP_HALT = 4'd11;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_WB,
      S_STOP
   } state_t;

   state_t state_q, state_d;

   logic [15:0]    ir;
   logic [DW-1:0]  regs [8];
   logic [DW-1:0]  opa, opb, res_q;
   logic [PCW-1:0] npc_q;

   logic [3:0]     op;
   logic [2:0]     rd, ra, rb;
   logic [DW-1:0]  imm6_dw, imm9_dw;
   logic [PCW-1:0] imm9_pc;

   logic [DW-1:0]  alu_res;
   logic [DW:0]    alu_sum;
   logic [PCW-1:0] alu_npc;
   logic           alu_c;
   logic           alu_flags;

   assign op = ir[15:12];
   assign rd = ir[11:9];
   assign ra = ir[8:6];
   assign rb = ir[5:3];

   assign imm6_dw = DW'($signed(ir[5:0]));
   assign imm9_dw = DW'($signed(ir[8:0]));
   assign imm9_pc = PCW'($signed(ir[8:0]));

   function automatic logic [DW-1:0] rf_read(input logic [2:0] a);
      return (a == 3'd0) ? '0 : regs[a];
   endfunction

   assign dbg_rdata = rf_read(dbg_raddr);
   assign imem_addr = pc;

   // Fetch handshake: imem_req is high for the whole FETCH state with a stable
   // imem_addr; the word on imem_rdata is taken on the first edge where
   // imem_req && imem_ack, and imem_rdata is ignored on every other edge.
   always_comb begin
      state_d  = state_q;
      imem_req = 1'b0;
      retire   = 1'b0;
      case (state_q)
         S_FETCH: begin
            imem_req = rst_n;
            if (imem_ack) state_d = S_DECODE;
         end
         S_DECODE: state_d = S_EXEC;
         S_EXEC:   state_d = S_WB;
         S_WB: begin
            retire  = 1'b1;
            state_d = (op >= OP_HALT) ? S_STOP : S_FETCH;
         end
         S_STOP:   state_d = S_STOP;
         default:  state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_FETCH;
      else        state_q <= state_d;
   end

   always_comb begin
      alu_res   = '0;
      alu_sum   = '0;
      alu_c     = 1'b0;
      alu_flags = 1'b0;
      alu_npc   = pc + PCW'(1);
      case (op)
         OP_ADD: begin
            alu_sum   = {1'b0, opa} + {1'b0, opb};
            alu_res   = alu_sum[DW-1:0];
            alu_c     = alu_sum[DW];
            alu_flags = 1'b1;
         end
         OP_SUB: begin
            alu_res   = opa - opb;
            alu_c     = (opa >= opb);
            alu_flags = 1'b1;
         end
         OP_AND: begin
            alu_res   = opa & opb;
            alu_flags = 1'b1;
         end
         OP_OR: begin
            alu_res   = opa | opb;
            alu_flags = 1'b1;
         end
         OP_XOR: begin
            alu_res   = opa ^ opb;
            alu_flags = 1'b1;
         end
         OP_SLL: begin
            alu_res   = opa << opb[SHW-1:0];
            alu_flags = 1'b1;
         end
         OP_SRL: begin
            alu_res   = opa >> opb[SHW-1:0];
            alu_flags = 1'b1;
         end
         OP_ADDI: begin
            alu_sum   = {1'b0, opa} + {1'b0, imm6_dw};
            alu_res   = alu_sum[DW-1:0];
            alu_c     = alu_sum[DW];
            alu_flags = 1'b1;
         end
         OP_LDI:  alu_res = imm9_dw;
         OP_BEQZ: if (opa == '0) alu_npc = pc + PCW'(1) + imm9_pc;
         OP_JMP:  alu_npc = pc + PCW'(1) + imm9_pc;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc      <= RESET_PC;
         ir      <= '0;
         opa     <= '0;
         opb     <= '0;
         res_q   <= '0;
         npc_q   <= '0;
         carry   <= 1'b0;
         zero    <= 1'b0;
         halted  <= 1'b0;
         illegal <= 1'b0;
         for (int i = 0; i < 8; i++) regs[i] <= '0;
      end else begin
         case (state_q)
            S_FETCH: if (imem_ack) ir <= imem_rdata;
            S_DECODE: begin
               // BEQZ tests R[rd], so it rides on operand A.
               opa <= (op == OP_BEQZ) ? rf_read(rd) : rf_read(ra);
               opb <= rf_read(rb);
            end
            S_EXEC: begin
               res_q <= alu_res;
               npc_q <= alu_npc;
               if (alu_flags) begin
                  carry <= alu_c;
                  zero  <= (alu_res == '0);
               end
            end
            S_WB: begin
               if (op <= OP_LDI && rd != 3'd0) regs[rd] <= res_q;
               if (op == OP_HALT)     halted  <= 1'b1;
               else if (op > OP_HALT) illegal <= 1'b1;
               else                   pc      <= npc_q;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_core_mc.sv
// Directed bench for cpu_core_mc: small programs in a modelled instruction
// memory with configurable ack latency, checked against hand-computed results.
module tb_cpu_core_mc;

   localparam int DW  = 16;
   localparam int PCW = 8;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           imem_req;
   logic [PCW-1:0] imem_addr;
   logic           imem_ack;
   logic [15:0]    imem_rdata;
   logic [2:0]     dbg_raddr = 3'd0;
   logic [DW-1:0]  dbg_rdata;
   logic [PCW-1:0] pc;
   logic           carry, zero, retire, halted, illegal;

   logic [15:0]    mem [256];
   int             ack_delay = 0;
   int             n_tests = 0;
   int             n_fail = 0;
   int             cyc, rets;

   localparam logic [15:0] HALT = 16'hB000;

   cpu_core_mc #(.DW(DW), .PCW(PCW), .RESET_PC(8'd0)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata),
      .pc(pc), .carry(carry), .zero(zero),
      .retire(retire), .halted(halted), .illegal(illegal)
   );

   always #5 clk = ~clk;

   // Instruction memory responder: acks after ack_delay low cycles, drives
   // garbage on rdata whenever ack is low.
   initial begin
      int cnt = 0;
      imem_ack   = 1'b0;
      imem_rdata = 16'hFFFF;
      forever begin
         @(negedge clk);
         if (!imem_req) begin
            imem_ack   = 1'b0;
            imem_rdata = 16'hFFFF;
            cnt        = 0;
         end else if (cnt >= ack_delay) begin
            imem_ack   = 1'b1;
            imem_rdata = mem[imem_addr];
         end else begin
            imem_ack   = 1'b0;
            imem_rdata = 16'($urandom);
            cnt++;
         end
      end
   end

   function automatic logic [15:0] i_r(input logic [3:0] op, input logic [2:0] d, a, b);
      return {op, d, a, b, 3'b000};
   endfunction
   function automatic logic [15:0] i_ldi(input logic [2:0] d, input logic [8:0] imm);
      return {4'h8, d, imm};
   endfunction
   function automatic logic [15:0] i_addi(input logic [2:0] d, a, input logic [5:0] imm);
      return {4'h7, d, a, imm};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reg(input string tag, input logic [2:0] a, input logic [31:0] exp);
      dbg_raddr = a;
      #1;
      chk(tag, 32'(dbg_rdata), exp);
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) mem[i] = HALT;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b1;
   endtask

   task automatic run(input string tag, input int budget, output int c, output int r);
      c = 0;
      r = 0;
      while (!(halted || illegal) && c < budget) begin
         @(negedge clk);
         if (retire) r++;
         @(posedge clk);
         #1;
         c++;
      end
      chk({tag, "_stopped"}, 32'(halted | illegal), 32'd1);
   endtask

   task automatic load_prog1();
      clear_mem();
      mem[0] = i_ldi(3'd1, 9'd5);
      mem[1] = i_ldi(3'd2, 9'd7);
      mem[2] = i_r(4'h0, 3'd3, 3'd1, 3'd2);
      mem[3] = HALT;
   endtask

   initial begin
      // Reset state
      load_prog1();
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_outs", {26'd0, imem_req, retire, halted, illegal, carry, zero}, 32'd0);
      chk("rst_pc", 32'(pc), 32'd0);
      chk_reg("rst_r1", 3'd1, 32'd0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      #1;
      chk("rel_req", 32'(imem_req), 32'd1);
      chk("rel_addr", 32'(imem_addr), 32'd0);

      // LDI/LDI/ADD/HALT, zero-wait
      run("p1", 200, cyc, rets);
      chk("p1_cyc", 32'(cyc), 32'd16);
      chk("p1_ret", 32'(rets), 32'd4);
      chk("p1_pc", 32'(pc), 32'd3);
      chk("p1_hi", {30'd0, halted, illegal}, 32'h2);
      chk_reg("p1_r3", 3'd3, 32'd12);
      chk("p1_cz", {30'd0, carry, zero}, 32'h0);

      // ADDI carry-out to zero, then SUB with no borrow
      clear_mem();
      mem[0] = i_ldi(3'd1, 9'h1FF);
      mem[1] = i_addi(3'd1, 3'd1, 6'd1);
      mem[2] = i_r(4'h1, 3'd2, 3'd0, 3'd1);
      do_reset();
      run("p2", 200, cyc, rets);
      chk_reg("p2_r1", 3'd1, 32'd0);
      chk_reg("p2_r2", 3'd2, 32'd0);
      chk("p2_cz", {30'd0, carry, zero}, 32'h3);
      chk("p2_pc", 32'(pc), 32'd3);

      // SUB with borrow, LDI leaves flags, LDI R0 discarded
      clear_mem();
      mem[0] = i_ldi(3'd1, 9'd3);
      mem[1] = i_ldi(3'd2, 9'd5);
      mem[2] = i_r(4'h1, 3'd3, 3'd1, 3'd2);
      mem[3] = i_ldi(3'd4, 9'd0);
      mem[4] = i_ldi(3'd0, 9'd9);
      do_reset();
      run("p3", 200, cyc, rets);
      chk_reg("p3_r3", 3'd3, 32'hFFFE);
      chk("p3_cz", {30'd0, carry, zero}, 32'h0);
      chk_reg("p3_r0", 3'd0, 32'd0);
      chk("p3_ret", 32'(rets), 32'd6);
      chk("p3_pc", 32'(pc), 32'd5);

      // Logic ops and shifts (shift amount 20 mod 16 = 4)
      clear_mem();
      mem[0] = i_ldi(3'd1, 9'h0F3);
      mem[1] = i_ldi(3'd2, 9'h1AA);
      mem[2] = i_r(4'h2, 3'd3, 3'd1, 3'd2);
      mem[3] = i_r(4'h3, 3'd4, 3'd1, 3'd2);
      mem[4] = i_r(4'h4, 3'd5, 3'd1, 3'd2);
      mem[5] = i_ldi(3'd6, 9'd20);
      mem[6] = i_r(4'h5, 3'd7, 3'd1, 3'd6);
      mem[7] = i_r(4'h6, 3'd6, 3'd2, 3'd6);
      do_reset();
      run("p4", 400, cyc, rets);
      chk_reg("p4_and", 3'd3, 32'h00A2);
      chk_reg("p4_or", 3'd4, 32'hFFFB);
      chk_reg("p4_xor", 3'd5, 32'hFF59);
      chk_reg("p4_srl", 3'd6, 32'h0FFA);
      chk_reg("p4_sll", 3'd7, 32'h0F30);
      chk("p4_pc", 32'(pc), 32'd8);

      // Countdown loop with BEQZ and backward JMP
      clear_mem();
      mem[0] = i_ldi(3'd1, 9'd3);
      mem[1] = i_addi(3'd1, 3'd1, 6'h3F);
      mem[2] = {4'h9, 3'd1, 9'd1};
      mem[3] = {4'hA, 3'd0, 9'h1FD};
      do_reset();
      run("loop", 400, cyc, rets);
      chk("loop_ret", 32'(rets), 32'd10);
      chk("loop_cyc", 32'(cyc), 32'd40);
      chk_reg("loop_r1", 3'd1, 32'd0);
      chk("loop_pc", 32'(pc), 32'd4);
      chk("loop_cz", {30'd0, carry, zero}, 32'h3);

      // Three wait states per fetch
      load_prog1();
      ack_delay = 3;
      do_reset();
      run("slow", 400, cyc, rets);
      chk("slow_cyc", 32'(cyc), 32'd28);
      chk("slow_ret", 32'(rets), 32'd4);
      chk_reg("slow_r3", 3'd3, 32'd12);
      chk("slow_pc", 32'(pc), 32'd3);

      // Illegal opcode at address 2
      ack_delay = 0;
      clear_mem();
      mem[0] = i_ldi(3'd1, 9'd5);
      mem[1] = i_ldi(3'd2, 9'd7);
      mem[2] = 16'hE650;
      do_reset();
      run("ill", 200, cyc, rets);
      chk("ill_hi", {30'd0, halted, illegal}, 32'h1);
      chk("ill_ret", 32'(rets), 32'd3);
      chk_reg("ill_r3", 3'd3, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("ill_pc", 32'(pc), 32'd2);
      chk("ill_stop", {30'd0, imem_req, retire}, 32'h0);

      // Reset asserted in the middle of a delayed fetch
      load_prog1();
      ack_delay = 3;
      do_reset();
      repeat (9) @(posedge clk);
      #1;
      chk("mid_pc", 32'(pc), 32'd1);
      chk("mid_req", 32'(imem_req), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_req_drop", 32'(imem_req), 32'd0);
      chk("mid_pc_rst", 32'(pc), 32'd0);
      chk_reg("mid_r1_rst", 3'd1, 32'd0);
      ack_delay = 0;
      do_reset();
      run("restart", 200, cyc, rets);
      chk("restart_cyc", 32'(cyc), 32'd16);
      chk_reg("restart_r3", 3'd3, 32'd12);
      chk("restart_pc", 32'(pc), 32'd3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
